// File: rtl/spi_scene_frontend.sv
`timescale 1ns/1ps
// SPI mode-0 slave loading a shadow scene register file, committed atomically to the active outputs on en_load.
// Latency: pins -> internal sck edge 3 clk; a written byte lands in shadow 1 clk after its 8th sck rise; commit 1 clk.
// Backpressure: none; the host paces bytes with sck (max clk/6); en_load in gated mode only commits with a pending request.
// Ports: clk/rst_n; cs_in/sck_in/mosi_in (async SPI in); miso_out/miso_oe; en_load (commit strobe);
//        bg_color_out, poly_*_out (packed, polygon 0 in LSBs), en_screen_out (active scene registers).
module spi_scene_frontend #(
    parameter int N_POLY       = 2,
    parameter int X_W          = 7,
    parameter int Y_W          = 6,
    parameter int COLOR_W      = 6,
    parameter int DEPTH_W      = 3,
    parameter int COMMIT_GATED = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs_in,
    input  logic                        sck_in,
    input  logic                        mosi_in,
    output logic                        miso_out,
    output logic                        miso_oe,
    input  logic                        en_load,
    output logic [COLOR_W-1:0]          bg_color_out,
    output logic [N_POLY*COLOR_W-1:0]   poly_color_out,
    output logic [N_POLY*X_W-1:0]       v0_x_out,
    output logic [N_POLY*Y_W-1:0]       v0_y_out,
    output logic [N_POLY*X_W-1:0]       v1_x_out,
    output logic [N_POLY*Y_W-1:0]       v1_y_out,
    output logic [N_POLY*X_W-1:0]       v2_x_out,
    output logic [N_POLY*Y_W-1:0]       v2_y_out,
    output logic [N_POLY*DEPTH_W-1:0]   poly_depth_out,
    output logic [N_POLY-1:0]           poly_enable_out,
    output logic                        en_screen_out
);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    // Synchronisers and sck edge detection
    logic [1:0] cs_s, sck_s, mosi_s;
    logic       sck_d;
    logic       cs_sync, sck_rise, sck_fall;

    // The chip-select synchroniser resets to "deselected" so leaving reset never looks like a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s   <= 2'b11;
            sck_s  <= 2'b00;
            mosi_s <= 2'b00;
            sck_d  <= 1'b0;
        end else begin
            cs_s   <= {cs_s[0], cs_in};
            sck_s  <= {sck_s[0], sck_in};
            mosi_s <= {mosi_s[0], mosi_in};
            sck_d  <= sck_s[1];
        end
    end

    assign cs_sync  = cs_s[1];
    assign sck_rise = sck_s[1] & ~sck_d;
    assign sck_fall = ~sck_s[1] & sck_d;

    // Frame FSM, shift registers and address pointer
    state_t      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_sr;
    logic [6:0]  addr;
    logic        load_pend;
    logic        wr_vld;
    logic [7:0]  wr_dat;
    logic [6:0]  wr_addr;
    logic [7:0]  rd_dat;

    assign rx_byte = {rx_sr, mosi_s[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            rx_sr     <= 7'd0;
            tx_sr     <= 8'd0;
            addr      <= 7'd0;
            load_pend <= 1'b0;
            wr_vld    <= 1'b0;
            wr_dat    <= 8'd0;
            wr_addr   <= 7'd0;
        end else begin
            wr_vld <= 1'b0;
            if (cs_sync) begin
                // Deselect discards any partial byte.
                state     <= IDLE;
                bit_cnt   <= 3'd0;
                rx_sr     <= 7'd0;
                tx_sr     <= 8'd0;
                load_pend <= 1'b0;
            end else begin
                if (state == IDLE)
                    state <= CMD;
                if (sck_rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            // A rise seen while still in IDLE belongs to the command byte.
                            IDLE, CMD: begin
                                addr      <= rx_byte[6:0];
                                state     <= rx_byte[7] ? WDATA : RDATA;
                                load_pend <= ~rx_byte[7];
                            end
                            WDATA: begin
                                wr_vld  <= 1'b1;
                                wr_dat  <= rx_byte;
                                wr_addr <= addr;
                                addr    <= addr + 7'd1;
                            end
                            default: begin
                                addr      <= addr + 7'd1;
                                load_pend <= 1'b1;
                            end
                        endcase
                    end
                end
                // Falling edges either load the next read byte or shift the current one out.
                if (sck_fall) begin
                    if (load_pend) begin
                        tx_sr     <= rd_dat;
                        load_pend <= 1'b0;
                    end else begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign miso_out = ~cs_sync & tx_sr[7];
    assign miso_oe  = ~cs_sync;

    // Shadow register file
    logic                sh_en_screen;
    logic [COLOR_W-1:0]  sh_bg;
    logic [COLOR_W-1:0]  sh_color [N_POLY];
    logic [X_W-1:0]      sh_v0x [N_POLY];
    logic [Y_W-1:0]      sh_v0y [N_POLY];
    logic [X_W-1:0]      sh_v1x [N_POLY];
    logic [Y_W-1:0]      sh_v1y [N_POLY];
    logic [X_W-1:0]      sh_v2x [N_POLY];
    logic [Y_W-1:0]      sh_v2y [N_POLY];
    logic [DEPTH_W-1:0]  sh_depth [N_POLY];
    logic [N_POLY-1:0]   sh_enable;
    logic                pending;
    logic                commit;

    // Readback mux; unmapped addresses and absent polygons read as zero.
    always_comb begin
        rd_dat = 8'd0;
        case (addr)
            7'h00: rd_dat[1:0] = {pending, sh_en_screen};
            7'h01: rd_dat[COLOR_W-1:0] = sh_bg;
            7'h02: begin
                rd_dat[7:4] = 4'(N_POLY);
                rd_dat[0]   = pending;
            end
            default: ;
        endcase
        for (int p = 0; p < N_POLY; p++) begin
            if (addr[6:3] == 4'(p + 1)) begin
                case (addr[2:0])
                    3'd0: rd_dat[COLOR_W-1:0] = sh_color[p];
                    3'd1: rd_dat[X_W-1:0]     = sh_v0x[p];
                    3'd2: rd_dat[Y_W-1:0]     = sh_v0y[p];
                    3'd3: rd_dat[X_W-1:0]     = sh_v1x[p];
                    3'd4: rd_dat[Y_W-1:0]     = sh_v1y[p];
                    3'd5: rd_dat[X_W-1:0]     = sh_v2x[p];
                    3'd6: rd_dat[Y_W-1:0]     = sh_v2y[p];
                    default: begin
                        rd_dat[7]           = sh_enable[p];
                        rd_dat[DEPTH_W-1:0] = sh_depth[p];
                    end
                endcase
            end
        end
    end

    assign commit = en_load && ((COMMIT_GATED == 0) || pending);

    // Commit copies the pre-write shadow; a write in the same cycle stays in shadow,
    // and a commit request written in the commit cycle survives as pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en_screen    <= 1'b0;
            sh_bg           <= '0;
            sh_enable       <= '0;
            pending         <= 1'b0;
            for (int p = 0; p < N_POLY; p++) begin
                sh_color[p] <= '0;
                sh_v0x[p]   <= '0;
                sh_v0y[p]   <= '0;
                sh_v1x[p]   <= '0;
                sh_v1y[p]   <= '0;
                sh_v2x[p]   <= '0;
                sh_v2y[p]   <= '0;
                sh_depth[p] <= '0;
            end
            en_screen_out   <= 1'b0;
            bg_color_out    <= '0;
            poly_color_out  <= '0;
            v0_x_out        <= '0;
            v0_y_out        <= '0;
            v1_x_out        <= '0;
            v1_y_out        <= '0;
            v2_x_out        <= '0;
            v2_y_out        <= '0;
            poly_depth_out  <= '0;
            poly_enable_out <= '0;
        end else begin
            if (commit) begin
                pending         <= 1'b0;
                en_screen_out   <= sh_en_screen;
                bg_color_out    <= sh_bg;
                poly_enable_out <= sh_enable;
                for (int p = 0; p < N_POLY; p++) begin
                    poly_color_out[p*COLOR_W +: COLOR_W] <= sh_color[p];
                    v0_x_out[p*X_W +: X_W]               <= sh_v0x[p];
                    v0_y_out[p*Y_W +: Y_W]               <= sh_v0y[p];
                    v1_x_out[p*X_W +: X_W]               <= sh_v1x[p];
                    v1_y_out[p*Y_W +: Y_W]               <= sh_v1y[p];
                    v2_x_out[p*X_W +: X_W]               <= sh_v2x[p];
                    v2_y_out[p*Y_W +: Y_W]               <= sh_v2y[p];
                    poly_depth_out[p*DEPTH_W +: DEPTH_W] <= sh_depth[p];
                end
            end
            if (wr_vld) begin
                case (wr_addr)
                    7'h00: begin
                        sh_en_screen <= wr_dat[0];
                        if (wr_dat[1])
                            pending <= 1'b1;
                    end
                    7'h01: sh_bg <= wr_dat[COLOR_W-1:0];
                    default: ;
                endcase
                for (int p = 0; p < N_POLY; p++) begin
                    if (wr_addr[6:3] == 4'(p + 1)) begin
                        case (wr_addr[2:0])
                            3'd0: sh_color[p] <= wr_dat[COLOR_W-1:0];
                            3'd1: sh_v0x[p]   <= wr_dat[X_W-1:0];
                            3'd2: sh_v0y[p]   <= wr_dat[Y_W-1:0];
                            3'd3: sh_v1x[p]   <= wr_dat[X_W-1:0];
                            3'd4: sh_v1y[p]   <= wr_dat[Y_W-1:0];
                            3'd5: sh_v2x[p]   <= wr_dat[X_W-1:0];
                            3'd6: sh_v2y[p]   <= wr_dat[Y_W-1:0];
                            default: begin
                                sh_enable[p] <= wr_dat[7];
                                sh_depth[p]  <= wr_dat[DEPTH_W-1:0];
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_scene_frontend.sv
`timescale 1ns/1ps
// Bench for spi_scene_frontend: one ungated (index 0) and one gated (index 1) instance share the SPI pins.
// Latency: SPI half period 60 ns against a 10 ns clk.
// Backpressure: none; a byte-image model of the register map predicts readback and active outputs.
module tb_spi_scene_frontend;

    localparam int NP = 2, XW = 7, YW = 6, CW = 6, DW = 3;
    localparam int HP = 60;

    logic clk = 1'b0;
    logic rst_n, cs, sck, mosi;
    logic en_load [2];
    logic miso [2], moe [2], ens [2];
    logic [CW-1:0]    bg   [2];
    logic [NP*CW-1:0] pcol [2];
    logic [NP*XW-1:0] v0x [2], v1x [2], v2x [2];
    logic [NP*YW-1:0] v0y [2], v1y [2], v2y [2];
    logic [NP*DW-1:0] dep [2];
    logic [NP-1:0]    pen [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_scene_frontend #(
            .N_POLY(NP), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .DEPTH_W(DW), .COMMIT_GATED(g)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .cs_in(cs), .sck_in(sck), .mosi_in(mosi),
            .miso_out(miso[g]), .miso_oe(moe[g]), .en_load(en_load[g]),
            .bg_color_out(bg[g]), .poly_color_out(pcol[g]),
            .v0_x_out(v0x[g]), .v0_y_out(v0y[g]), .v1_x_out(v1x[g]), .v1_y_out(v1y[g]),
            .v2_x_out(v2x[g]), .v2_y_out(v2y[g]),
            .poly_depth_out(dep[g]), .poly_enable_out(pen[g]), .en_screen_out(ens[g])
        );
    end

    // Reference model: shadow as a 128-byte image, active as a snapshot per instance.
    logic [7:0] mem [128];
    logic [7:0] act [2][128];
    bit         pend [2];
    logic [7:0] wbuf [16];
    int checks = 0, failures = 0;
    int op, a, n;
    logic [7:0] tmp;

    function automatic logic [7:0] wmask(input int ad);
        if (ad == 0) return 8'h01;
        if (ad == 1) return 8'((1 << CW) - 1);
        if (ad < 8 || (ad / 8 - 1) >= NP) return 8'h00;
        case (ad % 8)
            0:       return 8'((1 << CW) - 1);
            1, 3, 5: return 8'((1 << XW) - 1);
            2, 4, 6: return 8'((1 << YW) - 1);
            default: return 8'(8'h80 | ((1 << DW) - 1));
        endcase
    endfunction

    function automatic logic [7:0] model_read(input int g, input int ad);
        if (ad == 0) return {6'd0, pend[g], mem[0][0]};
        if (ad == 2) return {4'(NP), 3'd0, pend[g]};
        return mem[ad];
    endfunction

    task automatic model_write(input int ad, input logic [7:0] d);
        mem[ad] = d & wmask(ad);
        if (ad == 0 && d[1]) begin
            pend[0] = 1'b1;
            pend[1] = 1'b1;
        end
    endtask

    task automatic model_commit(input int g);
        if (g == 0 || pend[g]) begin
            for (int i = 0; i < 128; i++) act[g][i] = mem[i];
            pend[g] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'd0; act[0][i] = 8'd0; act[1][i] = 8'd0;
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        logic [31:0] ec, e0x, e0y, e1x, e1y, e2x, e2y, ed, ee;
        int b;
        for (int g = 0; g < 2; g++) begin
            ec = 0; e0x = 0; e0y = 0; e1x = 0; e1y = 0; e2x = 0; e2y = 0; ed = 0; ee = 0;
            for (int p = 0; p < NP; p++) begin
                b = 8 + 8 * p;
                ec[p*CW +: CW]  = act[g][b][CW-1:0];
                e0x[p*XW +: XW] = act[g][b+1][XW-1:0];
                e0y[p*YW +: YW] = act[g][b+2][YW-1:0];
                e1x[p*XW +: XW] = act[g][b+3][XW-1:0];
                e1y[p*YW +: YW] = act[g][b+4][YW-1:0];
                e2x[p*XW +: XW] = act[g][b+5][XW-1:0];
                e2y[p*YW +: YW] = act[g][b+6][YW-1:0];
                ed[p*DW +: DW]  = act[g][b+7][DW-1:0];
                ee[p]           = act[g][b+7][7];
            end
            chk($sformatf("%s g%0d bg", tag, g), 32'(bg[g]), 32'(act[g][1][CW-1:0]));
            chk($sformatf("%s g%0d color", tag, g), 32'(pcol[g]), ec);
            chk($sformatf("%s g%0d v0x", tag, g), 32'(v0x[g]), e0x);
            chk($sformatf("%s g%0d v0y", tag, g), 32'(v0y[g]), e0y);
            chk($sformatf("%s g%0d v1x", tag, g), 32'(v1x[g]), e1x);
            chk($sformatf("%s g%0d v1y", tag, g), 32'(v1y[g]), e1y);
            chk($sformatf("%s g%0d v2x", tag, g), 32'(v2x[g]), e2x);
            chk($sformatf("%s g%0d v2y", tag, g), 32'(v2y[g]), e2y);
            chk($sformatf("%s g%0d depth", tag, g), 32'(dep[g]), ed);
            chk($sformatf("%s g%0d enable", tag, g), 32'(pen[g]), ee);
            chk($sformatf("%s g%0d en_screen", tag, g), 32'(ens[g]), 32'(act[g][0][0]));
        end
    endtask

    // Shifts nb bits MSB first; miso is sampled at the end of each low phase.
    // With collide set, en_load[0] is pulsed so it lands in the clk where the byte is written.
    task automatic spi_bits(input logic [7:0] d, input int nb, input bit collide,
                            output logic [7:0] r0, output logic [7:0] r1);
        r0 = 8'd0; r1 = 8'd0;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi = d[i];
            #HP;
            r0[i] = miso[0]; r1[i] = miso[1];
            sck = 1'b1;
            if (collide && i == 0) begin
                #30; en_load[0] = 1'b1;
                #10; en_load[0] = 1'b0;
                model_commit(0);
                #(HP - 40);
            end else begin
                #HP;
            end
            sck = 1'b0;
        end
    endtask

    task automatic spi_write(input int ad, input int cnt, input bit collide);
        logic [7:0] r0, r1;
        cs = 1'b0; #HP;
        spi_bits({1'b1, 7'(ad)}, 8, 1'b0, r0, r1);
        for (int k = 0; k < cnt; k++) begin
            spi_bits(wbuf[k], 8, collide && (k == cnt - 1), r0, r1);
            model_write(ad, wbuf[k]);
            ad = (ad + 1) % 128;
        end
        #HP; cs = 1'b1; #(2 * HP);
    endtask

    task automatic spi_read(input int ad, input int cnt, input string tag);
        logic [7:0] r0, r1;
        cs = 1'b0; #HP;
        spi_bits({1'b0, 7'(ad)}, 8, 1'b0, r0, r1);
        for (int k = 0; k < cnt; k++) begin
            spi_bits(8'h00, 8, 1'b0, r0, r1);
            chk($sformatf("%s g0 @%0h", tag, ad), 32'(r0), 32'(model_read(0, ad)));
            chk($sformatf("%s g1 @%0h", tag, ad), 32'(r1), 32'(model_read(1, ad)));
            ad = (ad + 1) % 128;
        end
        #HP; cs = 1'b1; #(2 * HP);
    endtask

    task automatic pulse_load(input bit e0, input bit e1, input int cyc, input string tag);
        @(negedge clk);
        en_load[0] = e0; en_load[1] = e1;
        repeat (cyc) @(negedge clk);
        en_load[0] = 1'b0; en_load[1] = 1'b0;
        repeat (cyc) begin
            if (e0) model_commit(0);
            if (e1) model_commit(1);
        end
        @(negedge clk);
        check_outs(tag);
    endtask

    initial begin
        logic [7:0] r0, r1;
        rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        en_load[0] = 1'b0; en_load[1] = 1'b0;
        model_reset();
        #20;
        check_outs("reset");
        chk("reset miso", 32'({miso[1], miso[0]}), 32'd0);
        chk("reset miso_oe", 32'({moe[1], moe[0]}), 32'd0);
        #40; rst_n = 1'b1; #(2 * HP);

        spi_read(2, 1, "status after reset");
        check_outs("idle after reset");

        // Burst write of polygon 0, nothing visible until commit
        wbuf[0] = 8'h15; wbuf[1] = 8'h7F; wbuf[2] = 8'h3F; wbuf[3] = 8'h01;
        wbuf[4] = 8'h02; wbuf[5] = 8'h03; wbuf[6] = 8'h04; wbuf[7] = 8'h83;
        spi_write(8, 8, 1'b0);
        check_outs("before commit");
        pulse_load(1'b1, 1'b0, 1, "burst commit");
        chk("poly0 color", 32'(pcol[0][5:0]), 32'h15);
        chk("poly0 v0x", 32'(v0x[0][6:0]), 32'h7F);
        chk("poly0 enable/depth", 32'({pen[0][0], dep[0][2:0]}), 32'hB);

        // Readback across the polygon boundary and an absent polygon
        spi_read(8'h0E, 3, "burst read");
        spi_read(8'h20, 1, "absent poly");
        wbuf[0] = 8'hFF;
        spi_write(1, 1, 1'b0);
        pulse_load(1'b1, 1'b0, 1, "bg commit");
        chk("bg masked", 32'(bg[0]), 32'h3F);

        // Gated commit
        wbuf[0] = 8'h2A;
        spi_write(1, 1, 1'b0);
        pulse_load(1'b0, 1'b1, 1, "gated no request");
        chk("gated bg held", 32'(bg[1]), 32'h00);
        wbuf[0] = 8'h03;
        spi_write(0, 1, 1'b0);
        spi_read(0, 1, "ctrl pending");
        pulse_load(1'b0, 1'b1, 1, "gated request");
        chk("gated bg", 32'(bg[1]), 32'h2A);
        chk("gated en_screen", 32'(ens[1]), 32'h1);
        spi_read(2, 1, "status after gated");

        // Aborted write after 5 data bits
        cs = 1'b0; #HP;
        spi_bits(8'h81, 8, 1'b0, r0, r1);
        spi_bits(8'h55, 5, 1'b0, r0, r1);
        cs = 1'b1; #(2 * HP);
        spi_read(1, 1, "after abort");

        // Write completing in the commit cycle
        wbuf[0] = 8'h11;
        spi_write(1, 1, 1'b1);
        @(negedge clk);
        check_outs("collision");
        chk("collision old bg", 32'(bg[0]), 32'h2A);
        pulse_load(1'b1, 1'b0, 1, "after collision");
        chk("collision new bg", 32'(bg[0]), 32'h11);

        // Randomised traffic
        for (int it = 0; it < 30; it++) begin
            op = int'($urandom_range(0, 2));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 8'h17));
            n = int'($urandom_range(1, 4));
            if (op == 0) begin
                for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                spi_write(a, n, 1'b0);
            end else if (op == 1) begin
                spi_read(a, n, "rand read");
            end else begin
                pulse_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           int'($urandom_range(1, 3)), "rand load");
            end
        end
        pulse_load(1'b1, 1'b1, 1, "final commit");

        // Reset in the middle of a read frame
        wbuf[0] = 8'h83;
        spi_write(15, 1, 1'b0);
        cs = 1'b0; #HP;
        spi_bits(8'h0F, 8, 1'b0, r0, r1);
        #HP;
        tmp = model_read(0, 15);
        chk("miso before reset", 32'(miso[0]), 32'(tmp[7]));
        chk("miso_oe in frame", 32'(moe[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("mid-frame reset");
        chk("miso in reset", 32'({miso[1], miso[0]}), 32'd0);
        chk("miso_oe in reset", 32'({moe[1], moe[0]}), 32'd0);
        #9; cs = 1'b1; #HP;
        rst_n = 1'b1; #(2 * HP);
        spi_read(2, 1, "status after mid reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
